// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// mult/multu/div/divu hold busy for a fixed number of cycles, then commit
// both HI and LO together at the final edge. mthi/mtlo write immediately.
// The arithmetic is done on the latched operands and sampled only at completion.
module mdu_multicycle #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic               sdiv, neg_a, neg_b, div_zero;
    logic [WIDTH-1:0]   num, den, den_nz, uq, ur, quo, rem;

    // Result datapath from latched operands. One 2W multiplier serves both
    // mult flavours via sign/zero extension; division runs on magnitudes and
    // fixes signs afterwards, which makes MIN/-1 wrap to MIN with remainder 0.
    always_comb begin
        ext_a    = {{WIDTH{1'b0}}, a_q};
        ext_b    = {{WIDTH{1'b0}}, b_q};
        if (op_q == OP_MULT) begin
            ext_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            ext_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end
        prod     = ext_a * ext_b;

        sdiv     = (op_q == OP_DIV);
        neg_a    = sdiv & a_q[WIDTH-1];
        neg_b    = sdiv & b_q[WIDTH-1];
        num      = neg_a ? -a_q : a_q;
        den      = neg_b ? -b_q : b_q;
        div_zero = (b_q == '0);
        den_nz   = div_zero ? WIDTH'(1) : den;
        uq       = num / den_nz;
        ur       = num % den_nz;
        quo      = (neg_a ^ neg_b) ? -uq : uq;
        rem      = neg_a ? -ur : ur;
    end

    // Control FSM: accept, count down, commit on the 1->0 step, or abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        case (mdu_op)
                            OP_MULT, OP_MULTU: begin
                                op_q  <= mdu_op;
                                a_q   <= src_a;
                                b_q   <= src_b;
                                cnt   <= MUL_N;
                                busy  <= 1'b1;
                                state <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q  <= mdu_op;
                                a_q   <= src_a;
                                b_q   <= src_b;
                                cnt   <= DIV_N;
                                busy  <= 1'b1;
                                state <= S_RUN;
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (cnt == CW'(1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                        if (op_q == OP_MULT || op_q == OP_MULTU) begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end else if (!div_zero) begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Bench for mdu_multicycle: a 32-bit default instance and an 8-bit/1/3 instance.
// Directed table, hand sequences for reset/cancel/ignored-start, and random ops
// checked against an arithmetic reference model.
module tb_mdu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, cancel;
    logic [2:0]  mdu_op;
    logic [31:0] src_a, src_b, hi, lo;
    logic        busy;
    logic        s8_start, s8_cancel;
    logic [2:0]  s8_op;
    logic [7:0]  s8_a, s8_b, hi8, lo8;
    logic        busy8;

    int total = 0;
    int bad   = 0;
    logic [31:0] mh [2];
    logic [31:0] ml [2];

    always #5 clk = ~clk;

    mdu_multicycle dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .busy(busy), .hi(hi), .lo(lo)
    );

    mdu_multicycle #(.WIDTH(8), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut8 (
        .clk(clk), .reset(reset), .start(s8_start), .mdu_op(s8_op),
        .src_a(s8_a), .src_b(s8_b), .cancel(s8_cancel),
        .busy(busy8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic cur_busy(input bit w8);
        return w8 ? busy8 : busy;
    endfunction

    function automatic logic [31:0] cur_hi(input bit w8);
        return w8 ? {24'h0, hi8} : hi;
    endfunction

    function automatic logic [31:0] cur_lo(input bit w8);
        return w8 ? {24'h0, lo8} : lo;
    endfunction

    function automatic int n_for(input bit w8, input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return w8 ? 1 : 5;
        if (op == 3'd3 || op == 3'd4) return w8 ? 3 : 10;
        return 0;
    endfunction

    task automatic drive(input bit w8, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic cn);
        if (w8) begin
            s8_start = st; s8_op = op; s8_a = a[7:0]; s8_b = b[7:0]; s8_cancel = cn;
        end else begin
            start = st; mdu_op = op; src_a = a; src_b = b; cancel = cn;
        end
    endtask

    function automatic longint sx(input logic [31:0] x, input int w);
        longint t;
        t = longint'({32'h0, x});
        return (t <<< (64 - w)) >>> (64 - w);
    endfunction

    // Reference: plain integer arithmetic on 64-bit values.
    task automatic model(input int sel, input int w, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        longint m, sa, sb, q, r;
        longint unsigned ua, ub, p;
        m  = (longint'(1) <<< w) - 1;
        sa = sx(a, w);
        sb = sx(b, w);
        ua = longint'({32'h0, a}) & m;
        ub = longint'({32'h0, b}) & m;
        case (op)
            3'd1: begin p = sa * sb; mh[sel] = 32'((p >> w) & m); ml[sel] = 32'(p & m); end
            3'd2: begin p = ua * ub; mh[sel] = 32'((p >> w) & m); ml[sel] = 32'(p & m); end
            3'd3: if (sb != 0) begin
                q = sa / sb; r = sa % sb;
                mh[sel] = 32'(r & m); ml[sel] = 32'(q & m);
            end
            3'd4: if (ub != 0) begin
                mh[sel] = 32'((ua % ub) & m); ml[sel] = 32'((ua / ub) & m);
            end
            3'd5: mh[sel] = 32'(ua);
            3'd6: ml[sel] = 32'(ua);
            default: ;
        endcase
    endtask

    // Issue one op, count busy cycles, optionally inject something on busy cycle
    // inj_at: kind 1 = start mult, 2 = cancel, 3 = start mthi. Checks vs model.
    task automatic run(input bit w8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int inj_at, input int kind,
                       input string nm, output int n);
        int sel, expn;
        sel = w8 ? 1 : 0;
        @(negedge clk);
        drive(w8, 1'b1, op, a, b, 1'b0);
        @(negedge clk);
        drive(w8, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        n = 0;
        while (cur_busy(w8) && n < 100) begin
            n++;
            if (n == inj_at) begin
                if (kind == 1) drive(w8, 1'b1, 3'd1, 32'd3, 32'd3, 1'b0);
                if (kind == 2) drive(w8, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
                if (kind == 3) drive(w8, 1'b1, 3'd5, 32'hDEAD, 32'h0, 1'b0);
            end
            @(negedge clk);
            drive(w8, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        end
        expn = n_for(w8, op);
        if (kind == 2 && inj_at >= 1 && inj_at <= expn) expn = inj_at;
        else model(sel, w8 ? 8 : 32, op, a, b);
        chk({nm, " busy_cycles"}, 32'(n), 32'(expn));
        chk({nm, " hi"}, cur_hi(w8), mh[sel]);
        chk({nm, " lo"}, cur_lo(w8), ml[sel]);
    endtask

    initial begin
        int n, nn, k;
        logic [2:0] op;
        logic [31:0] a, b;

        tbl[0]  = '{3'd1, 32'hFFFFFFFF, 32'h2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[1]  = '{3'd2, 32'hFFFFFFFF, 32'h2,        5,  32'h00000001, 32'hFFFFFFFE};
        tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        tbl[4]  = '{3'd4, 32'd100,      32'd7,        10, 32'd2,        32'd14};
        tbl[5]  = '{3'd5, 32'hAAAA,     32'h0,        0,  32'hAAAA,     32'd14};
        tbl[6]  = '{3'd6, 32'h5555,     32'h0,        0,  32'hAAAA,     32'h5555};
        tbl[7]  = '{3'd3, 32'd5,        32'd0,        10, 32'hAAAA,     32'h5555};
        tbl[8]  = '{3'd0, 32'h1234,     32'h1,        0,  32'hAAAA,     32'h5555};
        tbl[9]  = '{3'd7, 32'h1234,     32'h1,        0,  32'hAAAA,     32'h5555};
        tbl[10] = '{3'd1, 32'd7,        32'd6,        5,  32'd0,        32'd42};

        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        mh[0] = 0; ml[0] = 0; mh[1] = 0; ml[1] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy8", {31'h0, busy8}, 32'h0);

        // directed table
        for (int i = 0; i < 11; i++) begin
            run(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, 0, 0, $sformatf("tbl%0d", i), n);
            chk($sformatf("tbl%0d n_const", i), 32'(n), 32'(tbl[i].n));
            chk($sformatf("tbl%0d hi_const", i), hi, tbl[i].ehi);
            chk($sformatf("tbl%0d lo_const", i), lo, tbl[i].elo);
        end

        // divide by zero with a mult and an mthi issued while busy: both ignored
        run(1'b0, 3'd5, 32'hAAAA, 32'h0, 0, 0, "pre_mthi", n);
        run(1'b0, 3'd6, 32'h5555, 32'h0, 0, 0, "pre_mtlo", n);
        run(1'b0, 3'd3, 32'd5, 32'd0, 3, 1, "div0_ignore_mult", n);
        chk("div0 hi const", hi, 32'hAAAA);
        chk("div0 lo const", lo, 32'h5555);
        run(1'b0, 3'd4, 32'd9, 32'd2, 5, 3, "divu_ignore_mthi", n);

        // cancel on the 4th busy cycle, then a normal accept
        run(1'b0, 3'd4, 32'd100, 32'd7, 4, 2, "cancel4", n);
        chk("cancel4 n const", 32'(n), 32'd4);
        run(1'b0, 3'd4, 32'd100, 32'd7, 0, 0, "after_cancel", n);
        chk("after_cancel lo const", lo, 32'd14);

        // cancel while idle blocks mthi and mult
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd5, 32'h1234, 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd1, 32'd3, 32'd3, 1'b1);
        @(negedge clk);
        chk("idle_cancel busy", {31'h0, busy}, 32'h0);
        chk("idle_cancel hi", hi, mh[0]);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);

        // reset in the middle of a mult
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd1, 32'd7, 32'd6, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset busy", {31'h0, busy}, 32'h0);
        chk("midreset hi", hi, 32'h0);
        chk("midreset lo", lo, 32'h0);
        mh[0] = 0; ml[0] = 0; mh[1] = 0; ml[1] = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("postreset busy", {31'h0, busy}, 32'h0);
        chk("postreset hi", hi, 32'h0);
        chk("postreset lo", lo, 32'h0);

        // random ops, 32-bit
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                default: b = $urandom;
            endcase
            k = 0; nn = 0;
            if (op <= 3'd4 && $urandom_range(0, 3) == 0) begin
                k = 2; nn = $urandom_range(1, n_for(1'b0, op));
            end
            run(1'b0, op, a, b, nn, k, $sformatf("rnd32_%0d", i), n);
        end

        // narrow instance
        run(1'b1, 3'd1, 32'h80, 32'h80, 0, 0, "w8_mult", n);
        chk("w8_mult n const", 32'(n), 32'd1);
        chk("w8_mult hi const", {24'h0, hi8}, 32'h40);
        chk("w8_mult lo const", {24'h0, lo8}, 32'h00);
        run(1'b1, 3'd4, 32'hFF, 32'h10, 0, 0, "w8_divu", n);
        chk("w8_divu n const", 32'(n), 32'd3);
        chk("w8_divu hi const", {24'h0, hi8}, 32'h0F);
        chk("w8_divu lo const", {24'h0, lo8}, 32'h0F);
        for (int i = 0; i < 25; i++) begin
            op = 3'($urandom_range(1, 6));
            a = {24'h0, 8'($urandom)};
            b = ($urandom_range(0, 4) == 0) ? 32'h0 : {24'h0, 8'($urandom)};
            k = 0; nn = 0;
            if (op <= 3'd4 && $urandom_range(0, 3) == 0) begin
                k = 2; nn = $urandom_range(1, n_for(1'b1, op));
            end
            run(1'b1, op, a, b, nn, k, $sformatf("rnd8_%0d", i), n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Parametrised multiply/divide unit for the pipelined core; the next generation after the single-cycle datapath.
- Executes MIPS mult/multu/div/divu over a configurable number of cycles into internal HI/LO registers, and supports mthi/mtlo writes.
- Sits beside the ALU in the EX stage.
- Exposes busy so hazard control can stall mfhi/mflo and further MDU instructions.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (≥2)
MUL_CYCLES, 5, cycles busy is held for mult/multu (≥1)
DIV_CYCLES, 10, cycles busy is held for div/divu (≥1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  qualifies mdu_op for one cycle
mdu_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
src_a  input  WIDTH  rs operand / mthi-mtlo data
src_b  input  WIDTH  rt operand
cancel  input  1  abort in-flight operation (exception flush)
busy  output  1  operation in flight
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset, asynchronous, active-high: hi=0, lo=0, busy=0, cycle counter=0, latched op/operands cleared. Takes effect immediately, also mid-operation; the in-flight result is discarded.
- Accept: at a rising edge with start=1, busy=0, cancel=0.
  - Ops 1-4: operands and op latched; counter loaded with N (MUL_CYCLES or DIV_CYCLES); busy=1 from the next cycle.
  - Ops 5/6: hi (resp. lo) ← src_a at that edge; busy stays 0; no latency.
- Counting: each edge while busy=1 and cancel=0 decrements the counter. At the edge where the counter goes 1→0, hi/lo are written and busy falls at that same edge. Net timing: start sampled at edge T → busy high for exactly N cycles (edges T+1..T+N) → new hi/lo visible after edge T+N.
- hi/lo hold their old values throughout the operation; no partial results are ever visible.
- start while busy=1 is ignored (op, operands and counter unchanged). Control must stall; the unit does not queue. mthi/mtlo while busy are also ignored.
- cancel=1 at an edge with busy=1: busy←0, counter←0, hi/lo unchanged. cancel=1 with busy=0 blocks that cycle's start (including mthi/mtlo).
- mult: signed 2·WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
- multu: same, operands unsigned.
- div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - MIN/−1 case: lo=MIN, hi=0 (two's-complement wrap, no trap).
- divu: unsigned quotient/remainder.
- Divide by zero (src_b=0, div or divu): busy still runs the full DIV_CYCLES; hi/lo left unchanged at completion.
- Arithmetic may be computed combinationally at accept or at completion; only the visible timing above is normative.
- busy, hi and lo are registered outputs; no combinational path from inputs to outputs.

Test Plan:
- Reset mid-op: start mult 7×6; assert reset after 2 cycles → busy=0, hi=0, lo=0 immediately. Deassert and idle 10 cycles → hi/lo stay 0.
- Signed/unsigned mult: mult 0xFFFFFFFF×0x00000002 → after 5 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu same operands → hi=0x00000001, lo=0xFFFFFFFE. Check busy is high for exactly 5 cycles.
- Signed div: div −7 / 2 → after 10 cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. divu 100/7 → lo=14, hi=2.
- Divide by zero and ignored start: preload mthi 0xAAAA, mtlo 0x5555; div 5/0 → busy 10 cycles, then hi=0xAAAA, lo=0x5555. Issue start mult mid-busy → ignored; no extra busy cycles.
- Cancel: divu 100/7, cancel on 4th busy cycle → busy falls at that edge; hi/lo keep prior values. Next start with cancel=0 is accepted normally.
- Parameter sweep: WIDTH=8, MUL_CYCLES=1, DIV_CYCLES=3. mult 0x80×0x80 → hi=0x40, lo=0x00 after 1 busy cycle. divu 0xFF/0x10 → lo=0x0F, hi=0x0F after 3 cycles.
